// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register writeback countdowns gate issue on RAW/WAW hazards.
// Define SCOREBOARD_FWD_EN to let a result retiring next cycle forward instead of stall.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int LAT_MAX  = 7,
  localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CNT_W = $clog2(LAT_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid_in,
  output logic                issue_ready_out,
  input  logic                has_src1_in,
  input  logic                has_src2_in,
  input  logic [REG_W-1:0]    src1_in,
  input  logic [REG_W-1:0]    src2_in,
  input  logic                wb_en_in,
  input  logic [REG_W-1:0]    dest_in,
  input  logic [CNT_W-1:0]    lat_in,
  input  logic                flush_in,
  output logic [CNT_W-1:0]    fwd_sel_src1_out,
  output logic [CNT_W-1:0]    fwd_sel_src2_out,
  output logic [NUM_REGS-1:0] busy_out,
  output logic [15:0]         stall_count_out
);

`ifdef SCOREBOARD_FWD_EN
  localparam logic [CNT_W-1:0] THR = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] THR = '0;
`endif
  localparam logic [CNT_W-1:0] LAT_CAP = CNT_W'(LAT_MAX);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_s1, cnt_s2, cnt_dst, lat_eff;
  logic             haz_s1, haz_s2, haz_waw;
  logic             issue, load_en;
  logic [15:0]      stall_q, stall_d;

  assign cnt_s1  = cnt_q[src1_in];
  assign cnt_s2  = cnt_q[src2_in];
  assign cnt_dst = cnt_q[dest_in];
  assign lat_eff = (lat_in > LAT_CAP) ? LAT_CAP : lat_in;

  assign haz_s1  = has_src1_in && (cnt_s1 > THR);
  assign haz_s2  = has_src2_in && (cnt_s2 > THR);
  // A younger write must not retire before an older in-flight write to the same register.
  assign haz_waw = wb_en_in && (cnt_dst > lat_eff);

  assign issue_ready_out = !(rst || haz_s1 || haz_s2 || haz_waw);
  assign issue           = issue_valid_in && issue_ready_out && !flush_in;
  assign load_en         = issue && wb_en_in && (lat_in != '0);

`ifdef SCOREBOARD_FWD_EN
  assign fwd_sel_src1_out = (has_src1_in && !haz_s1) ? cnt_s1 : '0;
  assign fwd_sel_src2_out = (has_src2_in && !haz_s2) ? cnt_s2 : '0;
`else
  assign fwd_sel_src1_out = '0;
  assign fwd_sel_src2_out = '0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic             load;
    logic [CNT_W-1:0] cnt_d;

    assign load = load_en && (dest_in == REG_W'(g));

    always_comb begin
      cnt_d = cnt_q[g];
      if (load)
        cnt_d = lat_eff;
      else if (cnt_q[g] != '0)
        cnt_d = cnt_q[g] - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q[g] <= '0;
      else     cnt_q[g] <= cnt_d;
    end

    assign busy_out[g] = |cnt_q[g];
  end

  always_comb begin
    stall_d = stall_q;
    if (issue_valid_in && !issue_ready_out && !flush_in && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count_out = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: table of per-cycle vectors checked through an expectation queue,
// plus hand sequences for long-latency busy, stall saturation and mid-stall reset.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_FWD_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif
  localparam int FW = (T == 1) ? 1 : 0;
  localparam int NF = 1 - FW;
  localparam int S0 = 2 + NF;
  localparam int S1 = S0 + NF;
  localparam int S2 = S1 + 4 + NF;
  localparam int B0 = 1, B2 = 1 << 2, B3 = 1 << 3, B5 = 1 << 5, B8 = 1 << 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        vld_a, rdy_a, h1_a, h2_a, wb_a, fl_a;
  logic [3:0]  s1_a, s2_a, d_a;
  logic [2:0]  lat_a, f1_a, f2_a;
  logic [15:0] busy_a, stall_a;

  // wide instance
  logic        vld_b, rdy_b, h1_b, h2_b, wb_b, fl_b;
  logic [4:0]  s1_b, s2_b, d_b;
  logic [3:0]  lat_b, f1_b, f2_b;
  logic [31:0] busy_b;
  logic [15:0] stall_b;

  reg_scoreboard dut_a (
    .clk(clk), .rst(rst), .issue_valid_in(vld_a), .issue_ready_out(rdy_a),
    .has_src1_in(h1_a), .has_src2_in(h2_a), .src1_in(s1_a), .src2_in(s2_a),
    .wb_en_in(wb_a), .dest_in(d_a), .lat_in(lat_a), .flush_in(fl_a),
    .fwd_sel_src1_out(f1_a), .fwd_sel_src2_out(f2_a),
    .busy_out(busy_a), .stall_count_out(stall_a));

  reg_scoreboard #(.NUM_REGS(32), .LAT_MAX(15)) dut_b (
    .clk(clk), .rst(rst), .issue_valid_in(vld_b), .issue_ready_out(rdy_b),
    .has_src1_in(h1_b), .has_src2_in(h2_b), .src1_in(s1_b), .src2_in(s2_b),
    .wb_en_in(wb_b), .dest_in(d_b), .lat_in(lat_b), .flush_in(fl_b),
    .fwd_sel_src1_out(f1_b), .fwd_sel_src2_out(f2_b),
    .busy_out(busy_b), .stall_count_out(stall_b));

  typedef struct {
    logic        vld, fl, h1, h2, wb;
    logic [3:0]  s1, s2, d;
    logic [2:0]  lat;
    logic        rdy;
    logic [2:0]  f1, f2;
    logic [15:0] busy, stall;
  } vec_t;

  vec_t tbl[28];
  vec_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input int vld, fl, h1, s1, h2, s2, wb, d, lat,
                              rdy, f1, f2, busy, stall);
    vec_t v;
    v.vld = vld[0]; v.fl = fl[0]; v.h1 = h1[0]; v.s1 = s1[3:0];
    v.h2 = h2[0]; v.s2 = s2[3:0]; v.wb = wb[0]; v.d = d[3:0]; v.lat = lat[2:0];
    v.rdy = rdy[0]; v.f1 = f1[2:0]; v.f2 = f2[2:0];
    v.busy = busy[15:0]; v.stall = stall[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    vld_a = v.vld; fl_a = v.fl; h1_a = v.h1; s1_a = v.s1; h2_a = v.h2;
    s2_a = v.s2; wb_a = v.wb; d_a = v.d; lat_a = v.lat;
  endtask

  task automatic idle_b();
    vld_b = 0; fl_b = 0; h1_b = 0; h2_b = 0; wb_b = 0;
    s1_b = '0; s2_b = '0; d_b = '0; lat_b = '0;
  endtask

  initial begin
    vec_t e;
    int   cyc;

    //             vld fl h1 s1 h2 s2 wb d lat  rdy f1 f2 busy   stall
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,     0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 1, 3, 3,  1, 0, 0, 0,     0);
    tbl[2]  = mk(1, 0, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0, B3,    0);
    tbl[3]  = mk(1, 0, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0, B3,    1);
    tbl[4]  = mk(1, 0, 1, 3, 0, 0, 0, 0, 0,  FW, FW, 0, B3,  2);
    tbl[5]  = mk(1, 0, 1, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0,     S0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 5, 1,  1, 0, 0, 0,     S0);
    tbl[7]  = mk(1, 0, 0, 0, 1, 5, 0, 0, 0,  FW, 0, FW, B5,  S0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,     S1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1, 2, 5,  1, 0, 0, 0,     S1);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 1, 2, 2,  0, 0, 0, B2,    S1);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 1, 2, 2,  0, 0, 0, B2,    S1 + 1);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 1, 2, 2,  0, 0, 0, B2,    S1 + 2);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 1, 2, 2,  1, 0, 0, B2,    S1 + 3);
    tbl[14] = mk(1, 0, 1, 2, 1, 2, 0, 0, 0,  0, 0, 0, B2,    S1 + 3);
    tbl[15] = mk(1, 0, 1, 2, 1, 2, 0, 0, 0,  FW, FW, FW, B2, S1 + 4);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,     S2);
    tbl[17] = mk(1, 1, 0, 0, 0, 0, 1, 7, 4,  1, 0, 0, 0,     S2);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,     S2);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 1, 8, 6,  1, 0, 0, 0,     S2);
    tbl[20] = mk(1, 1, 1, 8, 0, 0, 0, 0, 0,  0, 0, 0, B8,    S2);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, B8,    S2);
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 1, 9, 0,  1, 0, 0, B8,    S2);
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 1, 8, 0,  0, 0, 0, B8,    S2);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 1, 0, 7,  1, 0, 0, B8,    S2 + 1);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, B0|B8, S2 + 1);
    tbl[26] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, B0,    S2 + 1);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, B0,    S2 + 2);

    // reset with an issue attempt that must be ignored
    rst = 1'b1;
    drive_a(mk(1, 0, 0, 0, 0, 0, 1, 4, 5, 0, 0, 0, 0, 0));
    idle_b();
    vld_b = 1; wb_b = 1; d_b = 5'd4; lat_b = 4'd9;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst.rdy_a", rdy_a, 0);
    chk("rst.rdy_b", rdy_b, 0);
    chk("rst.busy_a", busy_a, 0);
    chk("rst.stall_a", stall_a, 0);
    chk("rst.busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_b();

    for (int i = 0; i < 28; i++) begin
      drive_a(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("step%0d.rdy", i),   rdy_a,   e.rdy);
      chk($sformatf("step%0d.fwd1", i),  f1_a,    e.f1);
      chk($sformatf("step%0d.fwd2", i),  f2_a,    e.f2);
      chk($sformatf("step%0d.busy", i),  busy_a,  e.busy);
      chk($sformatf("step%0d.stall", i), stall_a, e.stall);
      @(posedge clk); #1;
    end

    // long latency on the top register of the wide instance
    vld_b = 1; wb_b = 1; d_b = 5'd31; lat_b = 4'd15;
    @(negedge clk);
    chk("wide.rdy", rdy_b, 1);
    chk("wide.busy_pre", busy_b, 0);
    @(posedge clk); #1;
    idle_b();
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy_b[31]) cyc++;
      else break;
    end
    chk("wide.busy31_cycles", cyc, 15);

    // repeated self-dependent instruction keeps stalling until the counter saturates
    @(posedge clk); #1;
    drive_a(mk(1, 0, 1, 1, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0));
    for (int k = 0; k < 80000; k++) @(posedge clk);
    @(negedge clk);
    chk("sat.stall", stall_a, 16'hFFFF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("sat.rst_rdy", rdy_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_a(mk(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("post.busy_a", busy_a, 0);
    chk("post.stall_a", stall_a, 0);
    chk("post.rdy_a", rdy_a, 1);
    chk("post.fwd1_a", f1_a, 0);
    chk("post.fwd2_a", f2_a, 0);
    chk("post.busy_b", busy_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
